memoria_64: RTL and testbench
=============================

MEMORIA_64 -- requirements
Module: memoria_64

Interface
REQ-001 Parameter: RAM_SIZE, 4096, memory capacity in bytes; power of two, minimum 8.
REQ-002 Clk  input  1  clock; all state changes on its rising edge except reset.
REQ-003 nrst  input  1  reset; asynchronous and active-low.
REQ-004 raddress  input  64  byte address of the 64-bit read word.
REQ-005 waddress  input  64  byte address of the 64-bit write word.
REQ-006 Datain  input  64  write data.
REQ-007 Wr  input  1  write enable, active-high, sampled on the rising edge of Clk.
REQ-008 Dataout  output  64  registered read data.

Function
REQ-009 Storage SHALL be an array of RAM_SIZE bytes, byte-addressed.
REQ-010 Only address bits [log2(RAM_SIZE)-1:0] SHALL be used; upper address bits are ignored.
REQ-011 A 64-bit word at address A SHALL occupy bytes A..A+7, little-endian: byte A = bits [7:0], byte A+7 = bits [63:56].
REQ-012 Byte index A+i SHALL be computed modulo RAM_SIZE, so words that cross the top of memory wrap to byte 0.
REQ-013 Unaligned addresses SHALL be fully supported for both read and write; there is no alignment fault.
REQ-014 Write: on a rising Clk edge with nrst=1 and Wr=1, all 8 bytes at waddress SHALL be written from Datain.
REQ-015 With Wr=0, memory contents SHALL be unchanged.
REQ-016 Read: on every rising Clk edge with nrst=1, Dataout SHALL load the 8 bytes at raddress.
REQ-017 Read latency SHALL be 1 cycle: an address applied before edge N appears on Dataout after edge N.
REQ-018 Dataout SHALL hold its value between edges.
REQ-019 Read and write on the same edge SHALL be read-before-write: Dataout gets the pre-write contents of any overlapping bytes, and the new data is visible from the next edge.
REQ-020 Read and write on the same edge with non-overlapping bytes SHALL not interfere.
REQ-021 Memory contents after power-up SHALL be zero (initialised array).

Reset
REQ-022 While nrst=0, Dataout SHALL be 64'h0 immediately, without waiting for a Clk edge.
REQ-023 While nrst=0, no write SHALL occur, even with Wr=1.
REQ-024 Reset SHALL not clear memory contents; data written before reset remains readable after it.
REQ-025 After nrst rises, the first rising Clk edge SHALL perform normal read and write operations.
REQ-026 Reset asserted mid-operation SHALL cancel any write on an edge where nrst=0; writes completed before reset persist.

Verification
REQ-027 Sequential fill: write k*8 at address k*8 for k=1..8 on consecutive cycles with Wr=1, then read the same addresses on consecutive cycles -> Dataout equals k*8 one cycle after each address, and address 0 reads 0.
REQ-028 Unaligned: write 64'h0807060504030201 at 0 and 64'h100F0E0D0C0B0A09 at 8, read address 3 -> 64'h0B0A090807060504.
REQ-029 Wrap-around: write 64'h1122334455667788 at RAM_SIZE-4 -> bytes RAM_SIZE-4..RAM_SIZE-1 = 88,77,66,55 and bytes 0..3 = 44,33,22,11; reading RAM_SIZE-4 returns the same word; reading address RAM_SIZE+(RAM_SIZE-4) returns the same word (upper bits ignored).
REQ-030 Read-during-write: address 16 holds 64'hA; on one edge write 64'hB to 16 and read 16 -> Dataout=64'hA; next edge -> 64'hB.
REQ-031 Reset: with Dataout nonzero, drop nrst between edges -> Dataout=0 immediately; Wr=1 to address 24 during reset leaves address 24 unchanged; after release, earlier contents read back intact.
REQ-032 Write disable: Wr=0 with Datain=64'hFFFF_FFFF_FFFF_FFFF at address 40 -> subsequent read of 40 returns the prior value.

Source files
------------

// File: rtl/memoria_64.sv
// Byte-addressed RAM that is read and written as 64-bit little-endian words at any byte offset.
// Byte indices wrap modulo RAM_SIZE. Dataout is a registered read port that is cleared asynchronously.
module memoria_64 #(
    parameter int RAM_SIZE = 4096
) (
    input  logic        Clk,
    input  logic        nrst,
    input  logic [63:0] raddress,
    input  logic [63:0] waddress,
    input  logic [63:0] Datain,
    input  logic        Wr,
    output logic [63:0] Dataout
);
    localparam int AW = $clog2(RAM_SIZE);

    // Power-up contents are zero. Reset never touches the array.
    logic [7:0]    r_mem [RAM_SIZE] = '{default: 8'h00};
    logic [63:0]   r_dataout;
    logic [AW-1:0] w_rbase;
    logic [AW-1:0] w_wbase;
    logic [63:0]   w_rdata;
    logic          w_unused_addr;

    assign w_rbase       = raddress[AW-1:0];
    assign w_wbase       = waddress[AW-1:0];
    assign w_unused_addr = ^{raddress[63:AW], waddress[63:AW]};

    // AW-bit index arithmetic wraps words that cross the top of memory back to byte 0.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            w_rdata[i*8 +: 8] = r_mem[w_rbase + AW'(i)];
        end
    end

    always_ff @(posedge Clk) begin
        if (nrst && Wr) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_wbase + AW'(i)] <= Datain[i*8 +: 8];
            end
        end
    end

    // The read samples the array before this edge's write lands, which gives read-before-write.
    always_ff @(posedge Clk or negedge nrst) begin
        if (!nrst) begin
            r_dataout <= '0;
        end else begin
            r_dataout <= w_rdata;
        end
    end

    assign Dataout = r_dataout;

endmodule

// File: tb/tb_memoria_64.sv
// Randomised and directed bench for memoria_64. A byte-array reference model feeds an expected-read queue,
// and a monitor compares Dataout one cycle after each issued read.
module tb_memoria_64;
    localparam int RAM_SIZE = 4096;

    logic        Clk;
    logic        nrst;
    logic [63:0] raddress;
    logic [63:0] waddress;
    logic [63:0] Datain;
    logic        Wr;
    logic [63:0] Dataout;

    logic [7:0]  model_mem [RAM_SIZE];
    logic [63:0] exp_q[$];
    logic [63:0] addr_q[$];
    logic        rd_check;
    logic        mon_tag;
    int          n_checks;
    int          n_fail;

    memoria_64 #(.RAM_SIZE(RAM_SIZE)) dut (
        .Clk      (Clk),
        .nrst     (nrst),
        .raddress (raddress),
        .waddress (waddress),
        .Datain   (Datain),
        .Wr       (Wr),
        .Dataout  (Dataout)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int byte_idx(input logic [63:0] a, input int i);
        return int'((a + 64'(i)) % 64'(RAM_SIZE));
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = model_mem[byte_idx(a, i)];
        return r;
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) model_mem[byte_idx(a, i)] = d[i*8 +: 8];
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 64'($urandom_range(0, RAM_SIZE - 1));
            1:       return 64'($urandom_range(RAM_SIZE - 8, RAM_SIZE - 1));
            2:       return {$urandom, $urandom};
            default: return 64'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic check_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // One clock cycle, starting and ending at a falling edge. The model reads first, then writes.
    task automatic do_cycle(input logic wr, input logic [63:0] wa, input logic [63:0] wd,
                            input logic rd, input logic [63:0] ra);
        Wr       = wr;
        waddress = wa;
        Datain   = wd;
        raddress = ra;
        rd_check = rd && nrst;
        if (rd && nrst) begin
            exp_q.push_back(model_read(ra));
            addr_q.push_back(ra);
        end
        if (wr && nrst) model_write(wa, wd);
        @(negedge Clk);
    endtask

    always @(posedge Clk) mon_tag <= rd_check & nrst;

    always @(negedge Clk) begin
        if (mon_tag) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_underflow got=%h exp=none", Dataout);
            end else begin
                logic [63:0] e;
                logic [63:0] a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if (Dataout !== e) begin
                    n_fail++;
                    $display("FAIL read addr=%h got=%h exp=%h", a, Dataout, e);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rd_check = 1'b0;
        mon_tag  = 1'b0;
        nrst     = 1'b0;
        Wr       = 1'b0;
        waddress = '0;
        raddress = '0;
        Datain   = '0;
        for (int i = 0; i < RAM_SIZE; i++) model_mem[i] = 8'h00;

        repeat (3) @(negedge Clk);
        check_now("reset_state", Dataout, 64'h0);
        nrst = 1'b1;

        // Sequential fill, then read back starting at the untouched address 0.
        for (int k = 1; k <= 8; k++) do_cycle(1'b1, 64'(k * 8), 64'(k * 8), 1'b0, 64'h0);
        for (int k = 0; k <= 8; k++) do_cycle(1'b0, 64'h0, 64'h0, 1'b1, 64'(k * 8));

        // Unaligned read that straddles two words.
        do_cycle(1'b1, 64'd0, 64'h0807060504030201, 1'b0, 64'd0);
        do_cycle(1'b1, 64'd8, 64'h100F0E0D0C0B0A09, 1'b0, 64'd0);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd3);

        // A word that wraps past the top of memory, read back through several address aliases.
        do_cycle(1'b1, 64'(RAM_SIZE - 4), 64'h1122334455667788, 1'b0, 64'd0);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'(RAM_SIZE - 4));
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'(2 * RAM_SIZE - 4));
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd0);

        // Read and write on the same edge, with full overlap, partial overlap and no overlap.
        do_cycle(1'b1, 64'd16, 64'hA, 1'b0, 64'd0);
        do_cycle(1'b1, 64'd16, 64'hB, 1'b1, 64'd16);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd16);
        do_cycle(1'b1, 64'd100, 64'hCAFE_F00D_1234_5678, 1'b1, 64'd96);
        do_cycle(1'b1, 64'd200, 64'h5555_AAAA_5555_AAAA, 1'b1, 64'd56);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd96);

        // A write attempted with Wr low.
        do_cycle(1'b0, 64'd40, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd40);

        // Reset between edges: Dataout clears at once, writes are blocked, and memory survives.
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd8);
        #2 nrst = 1'b0;
        #1 check_now("reset_immediate", Dataout, 64'h0);
        do_cycle(1'b1, 64'd24, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'd24);
        check_now("reset_hold", Dataout, 64'h0);
        #2 nrst = 1'b1;
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd24);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd8);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b1, 64'd3);

        // Random traffic, with reads often aimed close to the write address.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] wa;
            logic [63:0] ra;
            wa = rand_addr();
            ra = ($urandom_range(0, 1) == 1) ? wa + 64'($urandom_range(0, 14)) - 64'd7 : rand_addr();
            do_cycle(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
                     1'($urandom_range(0, 3) != 0), ra);
        end

        do_cycle(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        do_cycle(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
        check_now("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
